// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
//   state_t    : sequencer FSM states
//   OP_*       : ALU opcode encodings driven on alu_sel
//   FLAG_*     : bit positions of {Z,C,V,S} in the flags vector
//   phase_of() : LED phase encoding for a given state
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        EXEC,
        SHOW
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_S = 0;

    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned CNT_W   = 4;

    // One-hot {LOAD_OP,LOAD_B,LOAD_A}; dark while executing or showing.
    function automatic logic [PHASE_W-1:0] phase_of(input state_t s);
        logic [PHASE_W-1:0] p;
        p = '0;
        case (s)
            LOAD_A:  p = 3'b001;
            LOAD_B:  p = 3'b010;
            LOAD_OP: p = 3'b100;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button front end: multi-stage synchronizer followed by a registered
// rising-edge detector.
//   clk, rst : clock, synchronous active-high reset (clears the chain)
//   btn      : raw asynchronous button level
//   pulse    : one-cycle pulse per synchronized rising edge (registered)
module btn_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // A held button produces a single pulse; it must drop for at least one
    // synchronized cycle before another pulse can occur.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn};
            prev  <= sync[SYNC_STAGES-1];
            pulse <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Operand/opcode entry sequencer in front of a combinational ALU.
//   clk, rst            : clock, synchronous active-high reset
//   sw                  : data switches, sampled on a btn_next pulse
//   btn_next, btn_clear : raw push buttons (advance / abort)
//   alu_a, alu_b        : registered operands to the ALU
//   alu_sel             : registered opcode to the ALU
//   alu_result/alu_flags: ALU outputs, captured after settling
//   result_q, flags_q   : captured result and {Z,C,V,S}
//   phase               : one-hot entry phase for LEDs, 000 in EXEC/SHOW
//   done                : one-cycle pulse on the first SHOW cycle
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sw,
    input  logic               btn_next,
    input  logic               btn_clear,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic [WIDTH-1:0]   result_q,
    output logic [FLAGS_W-1:0] flags_q,
    output logic [PHASE_W-1:0] phase,
    output logic               done
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic             next_p;
    logic             clear_p;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_next_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (next_p)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    // Sequencer FSM; clear behaves like reset and takes priority over next.
    always_ff @(posedge clk) begin
        if (rst || clear_p) begin
            state    <= LOAD_A;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            cnt      <= '0;
            phase    <= phase_of(LOAD_A);
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (next_p) begin
                        alu_a <= sw;
                        state <= LOAD_B;
                        phase <= phase_of(LOAD_B);
                    end
                end
                LOAD_B: begin
                    if (next_p) begin
                        alu_b <= sw;
                        state <= LOAD_OP;
                        phase <= phase_of(LOAD_OP);
                    end
                end
                LOAD_OP: begin
                    if (next_p) begin
                        alu_sel <= sw[SEL_W-1:0];
                        cnt     <= '0;
                        state   <= EXEC;
                        phase   <= phase_of(EXEC);
                    end
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == SETTLE_LAST) begin
                        result_q <= alu_result;
                        flags_q  <= alu_flags;
                        state    <= SHOW;
                        phase    <= phase_of(SHOW);
                        done     <= 1'b1;
                    end
                end
                SHOW: begin
                    if (next_p) begin
                        state <= LOAD_A;
                        phase <= phase_of(LOAD_A);
                    end
                end
                default: begin
                    state <= LOAD_A;
                    phase <= phase_of(LOAD_A);
                end
            endcase
        end
    end

endmodule
